video_wr_scheduler: RTL and testbench

Write scheduler and arbiter placed between the FPro bus video port and the video controller. It passes immediate register/frame-buffer writes straight through. Writes flagged as deferred are queued and replayed only after the next frame-start pulse, so sprite, OSD and bar reconfigurations land between frames without tearing. The two write streams share the single downstream video bus under fixed priority.

---
 rtl/video_wr_scheduler.sv | 136 +++++++++++++
 tb/tb_video_wr_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_wr_scheduler.sv
// Video write scheduler: immediate writes pass straight through, deferred writes are replayed after frame_start.
// Optional build macro VWS_DRAIN_LIMIT_EN caps each frame's drain at DRAIN_MAX entries.
module video_wr_scheduler #(
  parameter int DEPTH     = 16,
  parameter int DRAIN_MAX = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset_sys,
  input  logic                     cpu_cs,
  input  logic                     cpu_wr,
  input  logic                     cpu_defer,
  input  logic [20:0]              cpu_addr,
  input  logic [31:0]              cpu_wr_data,
  input  logic                     frame_start,
  input  logic                     clr_overflow,
  output logic                     video_cs,
  output logic                     video_wr,
  output logic [20:0]              video_addr,
  output logic [31:0]              video_wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     overflow,
  output logic                     draining
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef VWS_DRAIN_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   pending_q, pending_d, remaining_q, remaining_d, drain_load;
  logic            overflow_q, overflow_d, draining_q, draining_d, vcs_q, vcs_d;
  logic [20:0]     vaddr_q, vaddr_d;
  logic [31:0]     vdata_q, vdata_d;
  logic            imm_wr, dfr_wr, full_now, push, pop;

  logic [20:0]     mem_addr [DEPTH];
  logic [31:0]     mem_data [DEPTH];

  assign full_now = (pending_q == CW'(DEPTH));

  always_comb begin
    imm_wr = cpu_cs & cpu_wr & ~cpu_defer;
    dfr_wr = cpu_cs & cpu_wr & cpu_defer;
    push   = dfr_wr & ~full_now;
    // Immediate writes own the bus; a drain slot simply slips one cycle.
    pop    = (state_q == DRAIN) & ~imm_wr;

    drain_load = pending_q;
    if (LIMIT_EN && (int'(pending_q) > DRAIN_MAX)) drain_load = CW'(DRAIN_MAX);

    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    pending_d = pending_q + CW'(push) - CW'(pop);

    state_d     = state_q;
    remaining_d = remaining_q;
    if (state_q == IDLE) begin
      if (frame_start && (pending_q != '0)) begin
        state_d     = DRAIN;
        remaining_d = drain_load;
      end
    end else if (pop) begin
      remaining_d = remaining_q - CW'(1);
      if (remaining_q == CW'(1)) state_d = IDLE;
    end
    draining_d = (state_d == DRAIN);

    overflow_d = overflow_q;
    if (dfr_wr && full_now) overflow_d = 1'b1;
    if (clr_overflow) overflow_d = 1'b0;

    vcs_d   = imm_wr | pop;
    vaddr_d = '0;
    vdata_d = '0;
    if (imm_wr) begin
      vaddr_d = cpu_addr;
      vdata_d = cpu_wr_data;
    end else if (pop) begin
      vaddr_d = mem_addr[rd_ptr_q];
      vdata_d = mem_data[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_sys or posedge reset_sys) begin
    if (reset_sys) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pending_q   <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
      draining_q  <= 1'b0;
      vcs_q       <= 1'b0;
      vaddr_q     <= '0;
      vdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pending_q   <= pending_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
      draining_q  <= draining_d;
      vcs_q       <= vcs_d;
      vaddr_q     <= vaddr_d;
      vdata_q     <= vdata_d;
    end
  end

  // Storage needs no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= cpu_addr;
      mem_data[wr_ptr_q] <= cpu_wr_data;
    end
  end

  assign video_cs      = vcs_q;
  assign video_wr      = vcs_q;
  assign video_addr    = vaddr_q;
  assign video_wr_data = vdata_q;
  assign full          = full_now;
  assign pending       = pending_q;
  assign overflow      = overflow_q;
  assign draining      = draining_q;

endmodule

// File: tb/tb_video_wr_scheduler.sv
// Bench for video_wr_scheduler: directed table, hand-written corner sequences and random traffic against a queue model.
module tb_video_wr_scheduler;

  localparam int DEPTH     = 16;
  localparam int DRAIN_MAX = 8;

`ifdef VWS_DRAIN_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        cs;
    logic        wr;
    logic        defer;
    logic [20:0] addr;
    logic [31:0] data;
    logic        fs;
    logic        clr;
  } in_t;

  typedef struct packed {
    logic        vcs;
    logic        vwr;
    logic [20:0] vaddr;
    logic [31:0] vdata;
    logic        full;
    logic [4:0]  pending;
    logic        ovf;
    logic        drn;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  logic        clk_sys = 1'b0;
  logic        reset_sys = 1'b0;
  logic        cpu_cs = 1'b0, cpu_wr = 1'b0, cpu_defer = 1'b0;
  logic [20:0] cpu_addr = '0;
  logic [31:0] cpu_wr_data = '0;
  logic        frame_start = 1'b0, clr_overflow = 1'b0;
  logic        video_cs, video_wr, full, overflow, draining;
  logic [20:0] video_addr;
  logic [31:0] video_wr_data;
  logic [4:0]  pending;

  int nVectors = 0;
  int nMiscompares = 0;

  logic [52:0] mq[$];
  bit          mDraining = 1'b0;
  int          mRemaining = 0;
  bit          mOvf = 1'b0;
  out_t        mExp;

  video_wr_scheduler #(.DEPTH(DEPTH), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk_sys(clk_sys), .reset_sys(reset_sys),
    .cpu_cs(cpu_cs), .cpu_wr(cpu_wr), .cpu_defer(cpu_defer),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .frame_start(frame_start), .clr_overflow(clr_overflow),
    .video_cs(video_cs), .video_wr(video_wr),
    .video_addr(video_addr), .video_wr_data(video_wr_data),
    .full(full), .pending(pending), .overflow(overflow), .draining(draining)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic in_t mkIn(bit cs, bit wr, bit defer, logic [20:0] addr, logic [31:0] data, bit fs, bit clr);
    in_t r;
    r.cs = cs; r.wr = wr; r.defer = defer; r.addr = addr; r.data = data; r.fs = fs; r.clr = clr;
    return r;
  endfunction

  function automatic out_t mkOut(bit vcs, logic [20:0] a, logic [31:0] d, bit f, int p, bit o, bit dr);
    out_t r;
    r.vcs = vcs; r.vwr = vcs; r.vaddr = a; r.vdata = d; r.full = f; r.pending = 5'(p); r.ovf = o; r.drn = dr;
    return r;
  endfunction

  function automatic in_t idleIn();
    return mkIn(0, 0, 0, '0, '0, 0, 0);
  endfunction

  function automatic in_t immIn(logic [20:0] a, logic [31:0] d);
    return mkIn(1, 1, 0, a, d, 0, 0);
  endfunction

  function automatic in_t dfrIn(logic [20:0] a, logic [31:0] d);
    return mkIn(1, 1, 1, a, d, 0, 0);
  endfunction

  function automatic in_t fsIn();
    return mkIn(0, 0, 0, '0, '0, 1, 0);
  endfunction

  // Queue-level model: one call describes what the bus should show after one clock.
  task automatic modelStep(input in_t in);
    bit          imm, dfr, drnPre;
    int          sizePre;
    logic [52:0] e;
    imm     = in.cs & in.wr & ~in.defer;
    dfr     = in.cs & in.wr & in.defer;
    sizePre = mq.size();
    drnPre  = mDraining;
    mExp.vcs = 1'b0; mExp.vaddr = '0; mExp.vdata = '0;
    if (imm) begin
      mExp.vcs = 1'b1; mExp.vaddr = in.addr; mExp.vdata = in.data;
    end else if (drnPre) begin
      e = mq.pop_front();
      mExp.vcs = 1'b1; mExp.vaddr = e[52:32]; mExp.vdata = e[31:0];
      mRemaining--;
      if (mRemaining == 0) mDraining = 1'b0;
    end
    if (dfr) begin
      if (sizePre < DEPTH) mq.push_back({in.addr, in.data});
      else mOvf = 1'b1;
    end
    if (in.fs && !drnPre && sizePre > 0) begin
      mDraining  = 1'b1;
      mRemaining = (LIMIT_EN && sizePre > DRAIN_MAX) ? DRAIN_MAX : sizePre;
    end
    if (in.clr) mOvf = 1'b0;
    mExp.vwr = mExp.vcs;
    mExp.full = (mq.size() == DEPTH);
    mExp.pending = 5'(mq.size());
    mExp.ovf = mOvf;
    mExp.drn = mDraining;
  endtask

  task automatic modelReset();
    mq.delete();
    mDraining = 1'b0; mRemaining = 0; mOvf = 1'b0;
  endtask

  task automatic applyStimulus(input in_t in);
    cpu_cs = in.cs; cpu_wr = in.wr; cpu_defer = in.defer;
    cpu_addr = in.addr; cpu_wr_data = in.data;
    frame_start = in.fs; clr_overflow = in.clr;
    modelStep(in);
    @(posedge clk_sys);
    #1;
  endtask

  // Address/data are only meaningful while video_cs is high, except for the strict reset check.
  task automatic checkOutput(input string name, input out_t exp, input bit strict);
    out_t act;
    out_t cmpExp;
    act = mkOut(video_cs, video_addr, video_wr_data, full, int'(pending), overflow, draining);
    act.vwr = video_wr;
    cmpExp = exp;
    if (!strict && !exp.vcs) begin
      act.vaddr = '0; act.vdata = '0; cmpExp.vaddr = '0; cmpExp.vdata = '0;
    end
    nVectors++;
    if (act !== cmpExp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got cs=%b wr=%b addr=%h data=%h full=%b pend=%0d ovf=%b drn=%b, expected cs=%b wr=%b addr=%h data=%h full=%b pend=%0d ovf=%b drn=%b",
               name, act.vcs, act.vwr, act.vaddr, act.vdata, act.full, act.pending, act.ovf, act.drn,
               cmpExp.vcs, cmpExp.vwr, cmpExp.vaddr, cmpExp.vdata, cmpExp.full, cmpExp.pending, cmpExp.ovf, cmpExp.drn);
    end
  endtask

  task automatic run(input string name, input in_t in);
    applyStimulus(in);
    checkOutput(name, mExp, 1'b0);
  endtask

  task automatic runIdle(input string name, input int n);
    for (int i = 0; i < n; i++) run(name, idleIn());
  endtask

  task automatic doReset();
    reset_sys = 1'b1;
    modelReset();
    #2;
    checkOutput("reset_async", mkOut(0, '0, '0, 0, 0, 0, 0), 1'b1);
    @(posedge clk_sys);
    #1;
    reset_sys = 1'b0;
  endtask

  vec_t tbl[11];

  initial begin
    in_t r;

    tbl[0]  = '{idleIn(),                          mkOut(0, '0,       '0,        0, 0, 0, 0)};
    tbl[1]  = '{immIn(21'h0_0400, 32'h1234),       mkOut(1, 21'h0400, 32'h1234,  0, 0, 0, 0)};
    tbl[2]  = '{idleIn(),                          mkOut(0, '0,       '0,        0, 0, 0, 0)};
    tbl[3]  = '{dfrIn(21'h0_0010, 32'hAAAA_0001),  mkOut(0, '0,       '0,        0, 1, 0, 0)};
    tbl[4]  = '{dfrIn(21'h0_0020, 32'hBBBB_0002),  mkOut(0, '0,       '0,        0, 2, 0, 0)};
    tbl[5]  = '{dfrIn(21'h0_0030, 32'hCCCC_0003),  mkOut(0, '0,       '0,        0, 3, 0, 0)};
    tbl[6]  = '{fsIn(),                            mkOut(0, '0,       '0,        0, 3, 0, 1)};
    tbl[7]  = '{idleIn(),                          mkOut(1, 21'h0010, 32'hAAAA_0001, 0, 2, 0, 1)};
    tbl[8]  = '{idleIn(),                          mkOut(1, 21'h0020, 32'hBBBB_0002, 0, 1, 0, 1)};
    tbl[9]  = '{idleIn(),                          mkOut(1, 21'h0030, 32'hCCCC_0003, 0, 0, 0, 0)};
    tbl[10] = '{idleIn(),                          mkOut(0, '0,       '0,        0, 0, 0, 0)};

    #1;
    doReset();

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].in);
      checkOutput($sformatf("table%0d", i), tbl[i].exp, 1'b0);
    end

    // Immediate write lands in the second drain slot; queued entries slip one cycle.
    for (int i = 0; i < 4; i++) run("collide_push", dfrIn(21'(32'h100 + i), 32'hD000_0000 + i));
    run("collide_fs", fsIn());
    run("collide_drain0", idleIn());
    run("collide_imm", immIn(21'h1F_FFFF, 32'hFEED_BEEF));
    runIdle("collide_tail", 5);

    // Overflow: 17 pushes into a 16-deep queue, then clear racing a second drop.
    for (int i = 0; i < 17; i++) run("ovf_push", dfrIn(21'(32'h200 + i), 32'h0F00_0000 + i));
    checkOutput("ovf_full", mkOut(0, '0, '0, 1, 16, 1, 0), 1'b0);
    run("ovf_clr", idleIn() | mkIn(0, 0, 0, '0, '0, 0, 1));
    run("ovf_drop", dfrIn(21'h3FF, 32'hDEAD_0000));
    r = dfrIn(21'h3FE, 32'hDEAD_0001);
    r.clr = 1'b1;
    run("ovf_clr_vs_drop", r);
    run("ovf_fs", fsIn());
    runIdle("ovf_drain", LIMIT_EN ? 2 * DEPTH + 4 : DEPTH + 2);
    if (LIMIT_EN) begin
      run("ovf_fs2", fsIn());
      runIdle("ovf_drain2", DEPTH);
    end

    // Push and frame_start during DRAIN: only the original two entries drain now.
    run("dd_push", dfrIn(21'h500, 32'h5555_0001));
    run("dd_push", dfrIn(21'h501, 32'h5555_0002));
    run("dd_fs", fsIn());
    run("dd_pushD", dfrIn(21'h5DD, 32'h5555_DDDD));
    run("dd_fs_mid", fsIn());
    runIdle("dd_idle", 3);
    run("dd_fs_next", fsIn());
    runIdle("dd_drainD", 3);

    // Twelve entries: two frames under the drain limit, one frame otherwise.
    for (int i = 0; i < 12; i++) run("lim_push", dfrIn(21'(32'h600 + i), 32'h6600_0000 + i));
    run("lim_fs1", fsIn());
    runIdle("lim_frame1", 10);
    run("lim_fs2", fsIn());
    runIdle("lim_frame2", 6);

    // Reset asserted mid-drain clears everything without waiting for a clock.
    for (int i = 0; i < 5; i++) run("rst_push", dfrIn(21'(32'h700 + i), 32'h7700_0000 + i));
    run("rst_fs", fsIn());
    run("rst_drain", idleIn());
    doReset();
    run("rst_after", idleIn());
    run("rst_fs_empty", fsIn());
    runIdle("rst_quiet", 2);

    for (int i = 0; i < 600; i++) begin
      r.cs    = ($urandom % 4) != 0;
      r.wr    = ($urandom % 5) != 0;
      r.defer = ($urandom % 3) != 0;
      r.addr  = 21'($urandom);
      r.data  = $urandom;
      r.fs    = ($urandom % 20) == 0;
      r.clr   = ($urandom % 40) == 0;
      run("random", r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
